// File: rtl/retire_trace_unit.sv
// Commit-trace capture and end-of-program detection behind the writeback stage.
// Retired instructions are queued in a small first-word-fall-through FIFO and
// drained over a valid/ready port. Program end is recognised from an ECALL,
// the stack pointer returning to the top of memory, or a cycle timeout. After
// a short drain window, done is raised together with the exit cause.
module retire_trace_unit #(
   parameter logic [31:0] PC_INIT    = 32'h01000000,
   parameter logic [31:0] MEM_DEPTH  = 32'h00100000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          MAX_CYCLES = 100000,
   parameter int          DRAIN_CYC  = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         ret_valid,
   input  logic [31:0]  ret_pc,
   input  logic [31:0]  ret_insn,
   input  logic         ret_wen,
   input  logic [4:0]   ret_rd,
   input  logic [31:0]  ret_wdata,
   input  logic [31:0]  sp_value,
   output logic         trc_valid,
   input  logic         trc_ready,
   output logic [101:0] trc_data,
   output logic         overflow,
   output logic [15:0]  drop_count,
   output logic [31:0]  cycle_count,
   output logic         done,
   output logic [1:0]   exit_cause
);

   localparam int              PW         = $clog2(FIFO_DEPTH);
   localparam int              CW         = PW + 1;
   localparam logic [CW-1:0]   FULL_CNT   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]   CNT_ZERO   = CW'(1'b0);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
   localparam logic [PW-1:0]   PTR_ONE    = PW'(1'b1);
   localparam logic [31:0]     STACK_TOP  = PC_INIT + MEM_DEPTH;
   localparam logic [31:0]     TIMEOUT_AT = 32'(MAX_CYCLES - 1);
   localparam logic [15:0]     DRAIN_LOAD = 16'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t         state_r, state_s;
   logic [15:0]    drain_cnt_r, drain_cnt_s;
   logic [1:0]     exit_cause_r, cause_s;
   logic           done_r;
   logic           sp_armed_r;
   logic [31:0]    cycle_count_r;
   logic           ecall_s, sp_hit_s, timeout_s;

   logic [101:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_s;
   logic [CW-1:0]  count_r, count_s;
   logic           trc_valid_r;
   logic [101:0]   trc_data_r, entry_s, head_s;
   logic           overflow_r;
   logic [15:0]    drop_count_r;
   logic           push_s, pop_s, full_s, accept_s, drop_s;

   // End-of-program trigger conditions (SP arming is registered, so arm and hit never coincide)
   always_comb begin
      ecall_s   = ret_valid && (ret_insn[6:0] == 7'h73);
      sp_hit_s  = sp_armed_r && (sp_value == STACK_TOP);
      timeout_s = (cycle_count_r == TIMEOUT_AT);
   end

   // Run/drain/done sequencing: first trigger in RUN wins, later ones are ignored
   always_comb begin
      state_s     = state_r;
      drain_cnt_s = drain_cnt_r;
      cause_s     = exit_cause_r;
      case (state_r)
         ST_RUN: begin
            if (ecall_s) begin
               cause_s = 2'd1;
            end else if (sp_hit_s) begin
               cause_s = 2'd2;
            end else if (timeout_s) begin
               cause_s = 2'd3;
            end else begin
               cause_s = exit_cause_r;
            end
            if (ecall_s || sp_hit_s || timeout_s) begin
               drain_cnt_s = DRAIN_LOAD;
               state_s     = (DRAIN_CYC > 1) ? ST_DRAIN : ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // done lands exactly DRAIN_CYC cycles after the trigger cycle
            drain_cnt_s = drain_cnt_r - 16'd1;
            if (drain_cnt_r == 16'd1) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_s = ST_DONE;
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase
   end

   // Control state, exit cause, stack-pointer arming and cycle counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= ST_RUN;
         drain_cnt_r   <= 16'd0;
         exit_cause_r  <= 2'd0;
         done_r        <= 1'b0;
         sp_armed_r    <= 1'b0;
         cycle_count_r <= 32'd0;
      end else begin
         state_r      <= state_s;
         drain_cnt_r  <= drain_cnt_s;
         exit_cause_r <= cause_s;
         done_r       <= (state_s == ST_DONE);
         if (sp_value < STACK_TOP) begin
            sp_armed_r <= 1'b1;
         end
         if (state_r != ST_DONE) begin
            cycle_count_r <= cycle_count_r + 32'd1;
         end
      end
   end

   // FIFO push/pop decisions and the head entry to present next cycle
   always_comb begin
      entry_s  = {ret_pc, ret_insn, ret_wen, ret_rd, ret_wdata};
      push_s   = ret_valid && (state_r != ST_DONE);
      pop_s    = trc_valid_r && trc_ready;
      full_s   = (count_r == FULL_CNT);
      accept_s = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;
      count_s  = count_r + CW'(accept_s) - CW'(pop_s);
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      // An entry written this cycle is not yet in storage, so forward it when it becomes head
      if ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s)) begin
         head_s = entry_s;
      end else begin
         head_s = mem_r[rd_ptr_s];
      end
   end

   // Trace storage array (contents are don't-care until written)
   always_ff @(posedge clock) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // FIFO pointers, registered trace port and drop accounting
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= CNT_ZERO;
         trc_valid_r  <= 1'b0;
         trc_data_r   <= 102'd0;
         overflow_r   <= 1'b0;
         drop_count_r <= 16'd0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r    <= rd_ptr_s;
         count_r     <= count_s;
         trc_valid_r <= (count_s != CNT_ZERO);
         if (count_s != CNT_ZERO) begin
            trc_data_r <= head_s;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != 16'hFFFF) begin
               drop_count_r <= drop_count_r + 16'd1;
            end
         end
      end
   end

   assign trc_valid   = trc_valid_r;
   assign trc_data    = trc_data_r;
   assign overflow    = overflow_r;
   assign drop_count  = drop_count_r;
   assign cycle_count = cycle_count_r;
   assign done        = done_r;
   assign exit_cause  = exit_cause_r;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_retire_trace_unit;

   localparam logic [31:0] TOP   = 32'h01100000;
   localparam int          DEPTH = 8;
   localparam int          DRAIN = 3;
   localparam int          MAXC  = 100000;

   logic         clock = 1'b0;
   logic         reset;
   logic         ret_valid;
   logic [31:0]  ret_pc, ret_insn, ret_wdata, sp_value;
   logic         ret_wen;
   logic [4:0]   ret_rd;
   logic         trc_ready;

   logic         trc_valid, overflow, done;
   logic [101:0] trc_data;
   logic [15:0]  drop_count;
   logic [31:0]  cycle_count;
   logic [1:0]   exit_cause;

   logic         to_trc_valid, to_overflow, to_done;
   logic [101:0] to_trc_data;
   logic [15:0]  to_drop_count;
   logic [31:0]  to_cycle_count;
   logic [1:0]   to_exit_cause;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [101:0] mq[$];
   logic [101:0] m_last;
   bit           m_ovf, m_done, m_armed;
   int           m_drops, m_cnt, m_trig, m_k;
   logic [1:0]   m_cause;

   always #5 clock = ~clock;

   retire_trace_unit dut (
      .clock(clock), .reset(reset),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_insn(ret_insn), .ret_wen(ret_wen),
      .ret_rd(ret_rd), .ret_wdata(ret_wdata), .sp_value(sp_value),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data),
      .overflow(overflow), .drop_count(drop_count), .cycle_count(cycle_count),
      .done(done), .exit_cause(exit_cause)
   );

   retire_trace_unit #(.MAX_CYCLES(20)) dut_to (
      .clock(clock), .reset(reset),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_insn(ret_insn), .ret_wen(ret_wen),
      .ret_rd(ret_rd), .ret_wdata(ret_wdata), .sp_value(sp_value),
      .trc_valid(to_trc_valid), .trc_ready(trc_ready), .trc_data(to_trc_data),
      .overflow(to_overflow), .drop_count(to_drop_count), .cycle_count(to_cycle_count),
      .done(to_done), .exit_cause(to_exit_cause)
   );

   task automatic chk(input string tag, input logic [101:0] obs, input logic [101:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_last  = 102'd0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
      m_armed = 1'b0;
      m_drops = 0;
      m_cnt   = 0;
      m_trig  = -1;
      m_k     = 0;
      m_cause = 2'd0;
   endtask

   // one clock of behaviour, from the current inputs
   task automatic model_step();
      bit         active;
      logic [1:0] c;
      active = !m_done;
      if ((mq.size() != 0) && trc_ready) void'(mq.pop_front());
      if (active && m_trig < 0) begin
         c = 2'd0;
         if (ret_valid && ret_insn[6:0] == 7'h73) c = 2'd1;
         else if (m_armed && sp_value == TOP) c = 2'd2;
         else if (m_cnt == MAXC - 1) c = 2'd3;
         if (c != 2'd0) begin
            m_trig  = m_k;
            m_cause = c;
         end
      end
      if (active && ret_valid) begin
         if (mq.size() < DEPTH) mq.push_back({ret_pc, ret_insn, ret_wen, ret_rd, ret_wdata});
         else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
         end
      end
      if (active) m_cnt++;
      if (sp_value < TOP) m_armed = 1'b1;
      m_k++;
      if (m_trig >= 0 && m_k >= m_trig + DRAIN) m_done = 1'b1;
      if (mq.size() != 0) m_last = mq[0];
   endtask

   task automatic check_all();
      chk("trc_valid",   102'(trc_valid),   102'(mq.size() != 0));
      chk("trc_data",    trc_data,          m_last);
      chk("overflow",    102'(overflow),    102'(m_ovf));
      chk("drop_count",  102'(drop_count),  102'(16'(m_drops)));
      chk("cycle_count", 102'(cycle_count), 102'(32'(m_cnt)));
      chk("done",        102'(done),        102'(m_done));
      chk("exit_cause",  102'(exit_cause),  102'(m_cause));
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset) model_reset();
      else model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ret_valid = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic rand_ret(input bit v);
      ret_valid = v;
      ret_pc    = $urandom();
      ret_insn  = $urandom();
      if (ret_insn[6:0] == 7'h73) ret_insn[4] = 1'b0;
      ret_wen   = 1'($urandom_range(0, 1));
      ret_rd    = 5'($urandom());
      ret_wdata = $urandom();
   endtask

   initial begin
      int popped;
      logic [101:0] third;
      reset = 1'b0; trc_ready = 1'b0; sp_value = TOP;
      rand_ret(1'b0);

      // 5: timeout on the MAX_CYCLES=20 instance, cycle_count frozen at 22
      do_reset();
      trc_ready = 1'b1;
      chk("to_reset_cycles", 102'(to_cycle_count), 102'(32'd0));
      for (int i = 0; i < 26; i++) begin
         step();
         chk("to_exit_cause", 102'(to_exit_cause), 102'((m_k >= 20) ? 2'd3 : 2'd0));
         chk("to_done",       102'(to_done),       102'(m_k >= 22));
         chk("to_cycle_count", 102'(to_cycle_count), 102'(32'((m_k <= 22) ? m_k : 22)));
      end

      // 1: five retires drained in order
      do_reset();
      chk("rst_valid", 102'(trc_valid), 102'(1'b0));
      chk("rst_data",  trc_data,        102'd0);
      trc_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin rand_ret(1'b1); step(); end
      rand_ret(1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("t1_overflow", 102'(overflow), 102'(1'b0));
      chk("t1_done",     102'(done),     102'(1'b0));

      // 4: overflow with ready low, then full with pop+push
      do_reset();
      trc_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin rand_ret(1'b1); step(); end
      chk("t4_overflow", 102'(overflow),   102'(1'b1));
      chk("t4_drops",    102'(drop_count), 102'(16'd2));
      trc_ready = 1'b1;
      rand_ret(1'b1); step();
      chk("t4_pushpop_drops", 102'(drop_count), 102'(16'd2));
      rand_ret(1'b0);
      for (int i = 0; i < 10; i++) step();
      chk("t4_empty", 102'(trc_valid), 102'(1'b0));

      // 3: SP held at top never triggers; dip then restore triggers
      do_reset();
      for (int i = 0; i < 6; i++) begin
         trc_ready = 1'($urandom_range(0, 1));
         rand_ret(1'($urandom_range(0, 1)));
         step();
      end
      chk("t3_no_trig", 102'(exit_cause), 102'(2'd0));
      rand_ret(1'b0);
      sp_value = 32'h010FFFF0; step();
      sp_value = TOP; step();
      chk("t3_sp_cause", 102'(exit_cause), 102'(2'd2));
      for (int i = 0; i < 4; i++) step();
      chk("t3_done", 102'(done), 102'(1'b1));

      // 2: ECALL at cycle N=2; DRAIN retires captured, DONE retires not
      do_reset();
      trc_ready = 1'b0;
      rand_ret(1'b1); step();
      rand_ret(1'b1); step();
      rand_ret(1'b1); ret_insn = 32'h00000073; step();
      chk("t2_cause_n1", 102'(exit_cause), 102'(2'd1));
      chk("t2_done_n1",  102'(done),       102'(1'b0));
      rand_ret(1'b1); step();
      chk("t2_done_n2",  102'(done),       102'(1'b0));
      rand_ret(1'b1); step();
      chk("t2_done_n3",  102'(done),       102'(1'b1));
      rand_ret(1'b1); step();
      rand_ret(1'b1); step();
      rand_ret(1'b0);
      trc_ready = 1'b1;
      popped = 0;
      third = 102'd0;
      for (int i = 0; i < 8; i++) begin
         if (trc_valid) begin
            popped++;
            if (popped == 3) third = trc_data;
         end
         step();
      end
      chk("t2_entries",     102'(popped),        102'(5));
      chk("t2_ecall_entry", 102'(third[69:38]),  102'(32'h00000073));

      // 6: reset during DRAIN with 4 entries queued
      do_reset();
      trc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin rand_ret(1'b1); step(); end
      rand_ret(1'b1); ret_insn = 32'h00000073; step();
      rand_ret(1'b0); step();
      reset = 1'b0; step(); reset = 1'b1;
      chk("t6_valid", 102'(trc_valid),   102'(1'b0));
      chk("t6_data",  trc_data,          102'd0);
      chk("t6_ovf",   102'(overflow),    102'(1'b0));
      chk("t6_drops", 102'(drop_count),  102'(16'd0));
      chk("t6_cycle", 102'(cycle_count), 102'(32'd0));
      chk("t6_done",  102'(done),        102'(1'b0));
      chk("t6_cause", 102'(exit_cause),  102'(2'd0));
      for (int i = 0; i < 6; i++) step();
      chk("t6_no_pending", 102'(done), 102'(1'b0));

      // randomized traffic
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int i = 0; i < 100; i++) begin
            trc_ready = ($urandom_range(0, 1) == 0);
            rand_ret($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 49) == 0) ret_insn = {ret_insn[31:7], 7'h73};
            sp_value = ($urandom_range(0, 29) == 0) ? (TOP - 32'($urandom_range(4, 4096))) : TOP;
            step();
         end
         sp_value = TOP;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
